// File: rtl/keccak_arb_pkg.sv
// keccak_arb_pkg: shared types and constants for the two-requester hash-core arbiter.
//   state_e          : arbiter FSM states (IDLE, MSG_IN, DIG_OUT)
//   DIGEST_BYTES_DEF : default digest length in bytes
//   GNT_*            : one-hot grant encodings (00 = nobody owns the core)
package keccak_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MSG_IN  = 2'd1,
        DIG_OUT = 2'd2
    } state_e;

    localparam int DIGEST_BYTES_DEF = 64;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_S0   = 2'b01;
    localparam logic [1:0] GNT_S1   = 2'b10;

endpackage

// File: rtl/keccak_arb_pick.sv
// keccak_arb_pick: 2-way request picker producing a one-hot grant.
//   req[1:0] : in  - request lines, bit 0 = s0, bit 1 = s1
//   ptr      : in  - only with KECCAK_ARB_RR_EN; 1 = s1 favoured on contention
//   gnt[1:0] : out - one-hot pick, 00 when nobody requests
// Build option KECCAK_ARB_RR_EN: round-robin via ptr; otherwise s0 always wins.
module keccak_arb_pick
    import keccak_arb_pkg::*;
(
    input  logic [1:0] req,
`ifdef KECCAK_ARB_RR_EN
    input  logic       ptr,
`endif
    output logic [1:0] gnt
);

    always_comb begin
        gnt = GNT_NONE;
`ifdef KECCAK_ARB_RR_EN
        // Pointer only matters when both ask; a lone requester always wins.
        if (req == 2'b11) begin
            gnt = ptr ? GNT_S1 : GNT_S0;
        end else if (req[0]) begin
            gnt = GNT_S0;
        end else if (req[1]) begin
            gnt = GNT_S1;
        end
`else
        if (req[0]) begin
            gnt = GNT_S0;
        end else if (req[1]) begin
            gnt = GNT_S1;
        end
`endif
    end

endmodule

// File: rtl/keccak_arb.sv
// keccak_arb: shares one byte-stream hash core between two requesters.
// A requester owns the core for a whole message and its full digest
// (no preemption). IDLE arbitrates (1-cycle latency), MSG_IN forwards message
// bytes s<g> -> core, DIG_OUT forwards DIGEST_BYTES digest bytes core -> r<g>.
// Ports:
//   clk, reset_n                     : clock, async active-low reset
//   s0_*/s1_* (data,end,valid,ready) : message byte streams from requesters
//   r0_*/r1_* (data,valid,ready)     : digest byte streams to requesters
//   core_* (data,end,valid,ready)    : message byte stream to the core
//   core_dout*                       : digest byte stream from the core
//   grant                            : one-hot owner, 00 when idle
//   busy                             : high whenever not IDLE
// Build option KECCAK_ARB_RR_EN: round-robin arbitration (default: s0 priority).
module keccak_arb
    import keccak_arb_pkg::*;
#(
    parameter int DIGEST_BYTES = DIGEST_BYTES_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] s0_data,
    input  logic       s0_end,
    input  logic       s0_valid,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_end,
    input  logic       s1_valid,
    output logic       s1_ready,
    output logic [7:0] r0_data,
    output logic       r0_valid,
    input  logic       r0_ready,
    output logic [7:0] r1_data,
    output logic       r1_valid,
    input  logic       r1_ready,
    output logic [7:0] core_data,
    output logic       core_end,
    output logic       core_valid,
    input  logic       core_ready,
    input  logic [7:0] core_dout,
    input  logic       core_dout_valid,
    output logic       core_dout_ready,
    output logic [1:0] grant,
    output logic       busy
);

    localparam logic [7:0] LAST_IDX = 8'(DIGEST_BYTES - 1);

    state_e     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] pick_gnt;
    logic       sel1;

`ifdef KECCAK_ARB_RR_EN
    logic ptr_q, ptr_d;
`endif

    keccak_arb_pick u_pick (
        .req ({s1_valid, s0_valid}),
`ifdef KECCAK_ARB_RR_EN
        .ptr (ptr_q),
`endif
        .gnt (pick_gnt)
    );

    assign sel1    = grant_q[1];
    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);
    assign r0_data = core_dout;
    assign r1_data = core_dout;

    // Datapath muxing: everything qualified by state so idle/other-phase
    // handshakes stay at 0.
    always_comb begin
        core_data       = 8'h00;
        core_end        = 1'b0;
        core_valid      = 1'b0;
        s0_ready        = 1'b0;
        s1_ready        = 1'b0;
        r0_valid        = 1'b0;
        r1_valid        = 1'b0;
        core_dout_ready = 1'b0;
        case (state_q)
            MSG_IN: begin
                core_data  = sel1 ? s1_data  : s0_data;
                core_end   = sel1 ? s1_end   : s0_end;
                core_valid = sel1 ? s1_valid : s0_valid;
                s0_ready   = grant_q[0] & core_ready;
                s1_ready   = grant_q[1] & core_ready;
            end
            DIG_OUT: begin
                r0_valid        = grant_q[0] & core_dout_valid;
                r1_valid        = grant_q[1] & core_dout_valid;
                core_dout_ready = sel1 ? r1_ready : r0_ready;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
`ifdef KECCAK_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_gnt != GNT_NONE) begin
                    grant_d = pick_gnt;
                    state_d = MSG_IN;
                end
            end
            MSG_IN: begin
                if (core_valid && core_ready && core_end) begin
                    state_d = DIG_OUT;
                end
            end
            DIG_OUT: begin
                if (core_dout_valid && core_dout_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = 8'h00;
                        state_d = IDLE;
                        grant_d = GNT_NONE;
`ifdef KECCAK_ARB_RR_EN
                        // Whoever was just served yields on the next contention.
                        ptr_d   = grant_q[0];
`endif
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
                cnt_d   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= GNT_NONE;
            cnt_q   <= 8'h00;
`ifdef KECCAK_ARB_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
`ifdef KECCAK_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_keccak_arb.sv
// tb_keccak_arb: randomized self-checking bench for keccak_arb.
// The bench plays both requesters, both digest sinks and the hash core.
// A negedge monitor records every transfer and checks handshake rules
// against a bench-side view of the transaction phase; each scenario task
// then compares recorded streams with a model that derives grant order from
// the arbitration rule and routes the k-th digest to the k-th owner.
module tb_keccak_arb;

    localparam int DB = 64;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] s0_data, s1_data, r0_data, r1_data, core_data, core_dout;
    logic       s0_end, s1_end, s0_valid, s1_valid, s0_ready, s1_ready;
    logic       r0_valid, r1_valid, r0_ready, r1_ready;
    logic       core_end, core_valid, core_ready, core_dout_valid, core_dout_ready;
    logic [1:0] grant;
    logic       busy;

    always #5 clk = ~clk;

    keccak_arb #(.DIGEST_BYTES(DB)) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_data(s0_data), .s0_end(s0_end), .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_end(s1_end), .s1_valid(s1_valid), .s1_ready(s1_ready),
        .r0_data(r0_data), .r0_valid(r0_valid), .r0_ready(r0_ready),
        .r1_data(r1_data), .r1_valid(r1_valid), .r1_ready(r1_ready),
        .core_data(core_data), .core_end(core_end), .core_valid(core_valid),
        .core_ready(core_ready), .core_dout(core_dout),
        .core_dout_valid(core_dout_valid), .core_dout_ready(core_dout_ready),
        .grant(grant), .busy(busy)
    );

    int checks = 0;
    int failures = 0;
    int viol = 0;

    // Stimulus state
    logic [8:0] src0_q[$], src1_q[$];      // {end, data} pending per requester
    logic [7:0] dig_q[$];                  // digest bytes the core still has to emit
    int         core_mode = 0;             // 0: ready=1, 1: toggle, 2: random
    bit         dout_rand = 0, drop_en = 0, idle_dout = 0;
    bit         r_rdy0 = 1, r_rdy1 = 1;

    // Recorded traffic and model inputs
    logic [7:0] core_got[$], r0_got[$], r1_got[$], dig_log[$];
    logic [1:0] grant_log[$];
    logic [7:0] mb0[$], mb1[$];
    int         len0_q[$], len1_q[$];
    bit         rr_last1 = 1;              // model: last served was s1 (so s0 favoured)

    bit         in_msg = 0;
    logic [1:0] prev_grant = 2'b00;

    function automatic void note(input string what);
        viol++;
        if (viol <= 5) $display("  note: handshake rule broken (%s) at %0t", what, $time);
    endfunction

    // Monitor: values at negedge equal those sampled at the next posedge.
    always @(negedge clk) begin
        if (!reset_n) begin
            in_msg = 0;
            prev_grant = 2'b00;
        end else begin
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                in_msg = 1;
                grant_log.push_back(grant);
            end
            if (!(grant == 2'b00 || grant == 2'b01 || grant == 2'b10)) note("grant not one-hot");
            if (busy !== (grant != 2'b00)) note("busy vs grant");
            if (prev_grant != 2'b00 && grant != 2'b00 && grant != prev_grant) note("preempted");
            if (in_msg) begin
                if (core_valid !== (grant[1] ? s1_valid : s0_valid)) note("core_valid follow");
                if (core_valid && core_data !== (grant[1] ? s1_data : s0_data)) note("core_data");
                if ((grant[1] ? s1_ready : s0_ready) !== core_ready) note("granted ready");
                if ((grant[1] ? s0_ready : s1_ready) !== 1'b0) note("other ready");
                if (core_dout_ready || r0_valid || r1_valid) note("digest side active in msg");
            end else begin
                if (core_valid || s0_ready || s1_ready) note("msg side active");
                if (grant == 2'b00) begin
                    if (core_dout_ready || r0_valid || r1_valid) note("digest side active idle");
                end else begin
                    if ((grant[1] ? r1_valid : r0_valid) !== core_dout_valid) note("r_valid follow");
                    if ((grant[1] ? r0_valid : r1_valid) !== 1'b0) note("other r_valid");
                    if (core_dout_ready !== (grant[1] ? r1_ready : r0_ready)) note("dout_ready");
                end
            end
            if (s0_valid && s0_ready) void'(src0_q.pop_front());
            if (s1_valid && s1_ready) void'(src1_q.pop_front());
            if (r0_valid && r0_ready) r0_got.push_back(r0_data);
            if (r1_valid && r1_ready) r1_got.push_back(r1_data);
            if (core_dout_valid && core_dout_ready && dig_q.size() != 0) void'(dig_q.pop_front());
            if (core_valid && core_ready) begin
                core_got.push_back(core_data);
                if (core_end) begin
                    in_msg = 0;
                    for (int j = 0; j < DB; j++) begin
                        logic [7:0] d;
                        d = 8'($urandom_range(0, 255));
                        dig_q.push_back(d);
                        dig_log.push_back(d);
                    end
                end
            end
            prev_grant = grant;
        end
    end

    task automatic drive();
        s0_valid = (src0_q.size() != 0) && !(drop_en && $urandom_range(0, 2) == 0);
        s0_data  = (src0_q.size() != 0) ? src0_q[0][7:0] : 8'h00;
        s0_end   = (src0_q.size() != 0) ? src0_q[0][8] : 1'b0;
        s1_valid = (src1_q.size() != 0) && !(drop_en && $urandom_range(0, 2) == 0);
        s1_data  = (src1_q.size() != 0) ? src1_q[0][7:0] : 8'h00;
        s1_end   = (src1_q.size() != 0) ? src1_q[0][8] : 1'b0;
        case (core_mode)
            0:       core_ready = 1'b1;
            1:       core_ready = ~core_ready;
            default: core_ready = 1'($urandom_range(0, 1));
        endcase
        core_dout_valid = idle_dout ||
            (dig_q.size() != 0 && (!dout_rand || $urandom_range(0, 1) == 1));
        core_dout = (dig_q.size() != 0) ? dig_q[0] : 8'($urandom_range(0, 255));
        r0_ready = r_rdy0;
        r1_ready = r_rdy1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        #1;
    endtask

    task automatic add_byte(input int who, input logic [7:0] d, input bit e);
        if (who == 0) begin src0_q.push_back({e, d}); mb0.push_back(d); end
        else          begin src1_q.push_back({e, d}); mb1.push_back(d); end
    endtask

    task automatic add_msg(input int who, input int len);
        for (int i = 0; i < len; i++) add_byte(who, 8'($urandom_range(0, 255)), i == len - 1);
        if (who == 0) len0_q.push_back(len); else len1_q.push_back(len);
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        while (n < budget && (src0_q.size() != 0 || src1_q.size() != 0 ||
                              dig_q.size() != 0 || busy)) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s timeout: still busy after %0d cycles, expected idle", tag, n);
        end
    endtask

    function automatic int first_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
        int n;
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    // Model: decide who owns each message from the arbitration rule, then
    // build the expected core stream and per-requester digest streams.
    task automatic check_streams(input string tag);
        int order[$];
        logic [7:0] exp_core[$], exp_r0[$], exp_r1[$];
        int n0, n1, i0, i1, m0, m1, len, d, gbad;
        bit last1;
        n0 = len0_q.size(); n1 = len1_q.size();
        last1 = rr_last1;
        while (n0 > 0 || n1 > 0) begin
            int p;
`ifdef KECCAK_ARB_RR_EN
            if (n0 > 0 && n1 > 0) p = last1 ? 0 : 1;
            else                  p = (n0 > 0) ? 0 : 1;
`else
            p = (n0 > 0) ? 0 : 1;
`endif
            order.push_back(p);
            if (p == 0) n0--; else n1--;
            last1 = (p == 1);
        end
        rr_last1 = last1;
        i0 = 0; i1 = 0; m0 = 0; m1 = 0;
        foreach (order[k]) begin
            len = (order[k] == 0) ? len0_q[m0] : len1_q[m1];
            for (int j = 0; j < len; j++) begin
                if (order[k] == 0) exp_core.push_back(mb0[i0 + j]);
                else               exp_core.push_back(mb1[i1 + j]);
            end
            if (order[k] == 0) begin i0 += len; m0++; end else begin i1 += len; m1++; end
            for (int j = 0; j < DB; j++) begin
                logic [7:0] b;
                b = (k * DB + j < dig_log.size()) ? dig_log[k * DB + j] : 8'hxx;
                if (order[k] == 0) exp_r0.push_back(b); else exp_r1.push_back(b);
            end
        end
        checks++;
        gbad = (grant_log.size() != order.size()) ? 1 : 0;
        foreach (order[k])
            if (k < grant_log.size() && grant_log[k] !== (order[k] ? 2'b10 : 2'b01)) gbad = 1;
        if (gbad != 0) begin
            failures++;
            $display("FAIL %s grant_order: got %0d grants (first %b), expected %0d (first %b)",
                     tag, grant_log.size(), (grant_log.size() != 0) ? grant_log[0] : 2'b00,
                     order.size(), (order.size() != 0 && order[0] == 1) ? 2'b10 : 2'b01);
        end
        checks++;
        d = first_diff(core_got, exp_core);
        if (d >= 0) begin
            failures++;
            $display("FAIL %s core_stream: got %0d bytes, expected %0d, first diff at %0d",
                     tag, core_got.size(), exp_core.size(), d);
        end
        checks++;
        d = first_diff(r0_got, exp_r0);
        if (d >= 0) begin
            failures++;
            $display("FAIL %s r0_digest: got %0d bytes, expected %0d, first diff at %0d",
                     tag, r0_got.size(), exp_r0.size(), d);
        end
        checks++;
        d = first_diff(r1_got, exp_r1);
        if (d >= 0) begin
            failures++;
            $display("FAIL %s r1_digest: got %0d bytes, expected %0d, first diff at %0d",
                     tag, r1_got.size(), exp_r1.size(), d);
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL %s handshake_rules: %0d violations, expected 0", tag, viol);
        end
        viol = 0;
        core_got.delete(); r0_got.delete(); r1_got.delete(); dig_log.delete();
        grant_log.delete(); mb0.delete(); mb1.delete(); len0_q.delete(); len1_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        s0_valid = 1; s1_valid = 1; s0_data = 8'h11; s1_data = 8'h22; s0_end = 0; s1_end = 0;
        core_ready = 1; core_dout_valid = 1; core_dout = 8'h5a; r0_ready = 1; r1_ready = 1;
        #12;
        checks++;
        if ({grant, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_state: grant=%b busy=%b, expected 00/0", grant, busy);
        end
        checks++;
        if ({s0_ready, s1_ready, core_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_msg_side: s0r=%b s1r=%b cv=%b, expected 0", s0_ready, s1_ready, core_valid);
        end
        checks++;
        if ({core_dout_ready, r0_valid, r1_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_dig_side: cdr=%b r0v=%b r1v=%b, expected 0", core_dout_ready, r0_valid, r1_valid);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        core_mode = 0;
        drive();
        #1;
        step();
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL reset_release_idle: grant=%b, expected 00", grant);
        end
    endtask

    task automatic test_single();
        add_byte(0, 8'h61, 0); add_byte(0, 8'h62, 0); add_byte(0, 8'h63, 1);
        len0_q.push_back(3);
        step();
        checks++;
        if ({s0_ready, core_valid, grant} !== 4'b0000) begin
            failures++;
            $display("FAIL single_arb_cycle: s0r=%b cv=%b grant=%b, expected 0/0/00", s0_ready, core_valid, grant);
        end
        step();
        checks++;
        if ({grant, busy} !== 3'b011) begin
            failures++;
            $display("FAIL single_grant: grant=%b busy=%b, expected 01/1", grant, busy);
        end
        run_until_idle("single", 2000);
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL single_end_grant: grant=%b, expected 00", grant);
        end
        check_streams("single");
    endtask

    task automatic test_contention();
        core_mode = 2; dout_rand = 1;
        add_msg(1, 1);
        for (int i = 0; i < 3; i++) add_msg(0, $urandom_range(1, 6));
        for (int i = 0; i < 2; i++) add_msg(1, $urandom_range(1, 6));
        run_until_idle("contention", 8000);
        check_streams("contention");
        core_mode = 0; dout_rand = 0;
    endtask

    task automatic test_backpressure();
        int n = 0, sz;
        core_mode = 1;
        add_msg(0, 8);
        while (r0_got.size() < 10 && n < 2000) begin step(); n++; end
        r_rdy0 = 0;
        step();
        sz = r0_got.size();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (core_dout_ready !== 1'b0 || r0_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_stall_%0d: core_dout_ready=%b r0_valid=%b, expected 0/1", i, core_dout_ready, r0_valid);
            end
            if (i < 4) step();
        end
        @(negedge clk);
        #1;
        checks++;
        if (r0_got.size() != sz || sz < 10) begin
            failures++;
            $display("FAIL bp_no_progress: got %0d bytes, expected %0d (>=10)", r0_got.size(), sz);
        end
        r_rdy0 = 1;
        run_until_idle("backpressure", 2000);
        check_streams("backpressure");
        core_mode = 0;
    endtask

    task automatic test_drop();
        drop_en = 1; core_mode = 2; dout_rand = 1;
        add_msg(1, 12);
        run_until_idle("drop", 4000);
        check_streams("drop");
        drop_en = 0; core_mode = 0; dout_rand = 0;
    endtask

    task automatic test_idle_iso();
        idle_dout = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({core_dout_ready, r0_valid, r1_valid, busy} !== 4'b0000) begin
                failures++;
                $display("FAIL idle_iso_%0d: cdr=%b r0v=%b r1v=%b busy=%b, expected 0", i,
                         core_dout_ready, r0_valid, r1_valid, busy);
            end
        end
        idle_dout = 0;
        step();
    endtask

    task automatic test_reset_mid_digest();
        int n = 0;
        add_msg(0, 4);
        while (r0_got.size() < 20 && n < 2000) begin step(); n++; end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({grant, busy, r0_valid, core_dout_ready} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_mid_async: grant=%b busy=%b r0v=%b cdr=%b, expected all 0",
                     grant, busy, r0_valid, core_dout_ready);
        end
        checks++;
        if (r0_got.size() != 20) begin
            failures++;
            $display("FAIL reset_mid_point: digest bytes at reset=%0d, expected 20", r0_got.size());
        end
        // The core is reset with the arbiter: drop everything in flight.
        src0_q.delete(); src1_q.delete(); dig_q.delete();
        core_got.delete(); r0_got.delete(); r1_got.delete(); dig_log.delete();
        grant_log.delete(); mb0.delete(); mb1.delete(); len0_q.delete(); len1_q.delete();
        rr_last1 = 1; viol = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive();
        #1;
        add_msg(1, 2);
        step();
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_latency: grant=%b one edge after request, expected 00", grant);
        end
        step();
        checks++;
        if (grant !== 2'b10) begin
            failures++;
            $display("FAIL reset_mid_regrant: grant=%b, expected 10", grant);
        end
        run_until_idle("reset_mid", 2000);
        check_streams("reset_mid");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_drop();
        test_idle_iso();
        test_contention();
        test_reset_mid_digest();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keccak_arb.md
KECCAK_ARB -- requirements
Module: keccak_arb

Interface
REQ-001 SHALL have parameter: DIGEST_BYTES, 64, number of digest bytes returned per message (2..256).
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  sole clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- s0_data / s1_data  in  8  requester message byte.
- s0_end / s1_end  in  1  last byte of message.
- s0_valid / s1_valid  in  1  byte valid.
- s0_ready / s1_ready  out  1  byte accepted.
- r0_data / r1_data  out  8  digest byte to requester.
- r0_valid / r1_valid  out  1  digest byte valid.
- r0_ready / r1_ready  in  1  requester accepts digest byte.
- core_data  out  8  byte to hash core.
- core_end  out  1  last byte to core.
- core_valid  out  1  byte to core valid.
- core_ready  in  1  core accepts byte.
- core_dout  in  8  digest byte from core.
- core_dout_valid  in  1  digest byte valid.
- core_dout_ready  out  1  arbiter accepts digest byte.
- grant  out  2  one-hot owner; 2'b00 when idle.
- busy  out  1  high whenever state is not IDLE.
REQ-003 SHALL implement clk and reset_n as one clock, with reset_n asynchronous and active-low.

Function
REQ-004 SHALL implement FSM states IDLE, MSG_IN, DIG_OUT; one hash message is owned end-to-end by one requester, with no preemption.
REQ-005 IDLE: if any sX_valid is high, SHALL register the selected requester into grant and enter MSG_IN next cycle; all sX_ready SHALL be 0 in IDLE, giving 1-cycle arbitration latency.
REQ-006 MSG_IN SHALL forward combinationally from the granted requester: core_data, core_end and core_valid from sX; sX_ready = core_ready; the non-granted sY_ready SHALL be 0.
REQ-007 A transfer SHALL occur when valid and ready are both high; a transfer with end=1 SHALL move the FSM to DIG_OUT next cycle.
REQ-008 A requester dropping sX_valid mid-message SHALL keep its grant; core_valid SHALL follow it low.
REQ-009 DIG_OUT SHALL forward combinationally: rX_data = core_dout; rX_valid = core_dout_valid; core_dout_ready = rX_ready (granted X only); the non-granted rY_valid SHALL be 0.
REQ-010 The 8-bit byte counter SHALL increment on each digest transfer; on the transfer with count == DIGEST_BYTES-1 it SHALL clear, return to IDLE and set grant to 0; core_end_out is not used.
REQ-011 core_dout_ready SHALL be 0 in IDLE and MSG_IN; core_valid SHALL be 0 in IDLE and DIG_OUT.
REQ-012 Simultaneous s0_valid and s1_valid in IDLE SHALL be resolved per REQ-016/REQ-017.
REQ-013 A 1-byte message (end=1 on first byte) SHALL be legal.

Reset
REQ-014 Asserting reset_n low SHALL, asynchronously, set state=IDLE, grant=0, counter=0, busy=0, and RR pointer=0; all ready and valid outputs SHALL then evaluate to 0.
REQ-015 Reset mid-message or mid-digest SHALL abandon the transaction; the core SHALL be reset by the same reset_n.

Configuration
REQ-016 With KECCAK_ARB_RR_EN defined, arbitration SHALL be round-robin: the requester served last has lower priority, the pointer updates on return to IDLE, and the pointer resets to favour s0.
REQ-017 Without KECCAK_ARB_RR_EN, arbitration SHALL be fixed priority with s0 over s1, and the pointer logic SHALL be absent.

Structure
REQ-018 Package keccak_arb_pkg SHALL hold the state enum (IDLE, MSG_IN, DIG_OUT), the DIGEST_BYTES default and the grant encodings.
REQ-019 Sub-module keccak_arb_pick SHALL be the 2-way picker (requests and pointer in, one-hot grant out), compiled with or without KECCAK_ARB_RR_EN.

Verification
REQ-020 Single message: s0 sends 3 bytes 0x61,0x62,0x63 (end on 0x63), core_ready=1 -> core sees those bytes; grant=01; after 64 core_dout transfers, r0 receives all 64; grant=00; r1_valid never high.
REQ-021 Contention with RR_EN: s0 and s1 both valid at IDLE -> s0 is served first, then s1; repeated contention alternates 0,1,0,1.
REQ-022 Contention without RR_EN: both valid continuously -> s0 is granted every time; s1 starves.
REQ-023 Backpressure: core_ready toggles 1/0 per cycle and r0_ready is low for 5 cycles mid-digest -> no byte is lost or duplicated; the counter stalls and the digest order is preserved.
REQ-024 Reset mid-digest: reset_n is pulsed low at digest byte 20 -> grant=00, busy=0 immediately; the next s1 request is granted after 1 cycle.
REQ-025 Idle isolation: core_dout_valid=1 while in IDLE -> core_dout_ready=0 and r0_valid=r1_valid=0.
